// File: rtl/fft_bfly_align_if.sv
// Sample/result bundle between the twiddle multiplier, the A-leg source and the
// butterfly alignment stage.
interface fft_bfly_align_if #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
);
    logic                                  clr;
    logic                                  a_val;
    logic signed [DATA_WIDTH-1:0]          a_re;
    logic signed [DATA_WIDTH-1:0]          a_im;
    logic                                  b_val;
    logic signed [DATA_WIDTH-1:0]          b_re;
    logic signed [DATA_WIDTH-1:0]          b_im;
    logic signed [DATA_WIDTH-1:0]          x_re;
    logic signed [DATA_WIDTH-1:0]          x_im;
    logic signed [DATA_WIDTH-1:0]          y_re;
    logic signed [DATA_WIDTH-1:0]          y_im;
    logic                                  out_val;
    logic [$clog2(FIFO_DEPTH):0]           fifo_cnt;
    logic                                  err_ovf;
    logic                                  err_unf;

    modport master (
        output clr, a_val, a_re, a_im, b_val, b_re, b_im,
        input  x_re, x_im, y_re, y_im, out_val, fifo_cnt, err_ovf, err_unf
    );

    modport slave (
        input  clr, a_val, a_re, a_im, b_val, b_re, b_im,
        output x_re, x_im, y_re, y_im, out_val, fifo_cnt, err_ovf, err_unf
    );
endinterface

// File: rtl/fft_bfly_align.sv
// Radix-2 DIT butterfly: buffers A until the rotated W*B arrives, emits X=A+WB, Y=A-WB.
// Optional 1-bit stage scaling is enabled by defining FFT_BFLY_SCALE_EN.
module fft_bfly_align #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
) (
    input logic              clk,
    input logic              rst,
    fft_bfly_align_if.slave  bus
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    function automatic logic signed [DATA_WIDTH-1:0] reduce(input logic signed [DATA_WIDTH:0] v);
`ifdef FFT_BFLY_SCALE_EN
        return v[DATA_WIDTH:1];
`else
        return v[DATA_WIDTH-1:0];
`endif
    endfunction

    logic signed [DATA_WIDTH-1:0] mem_re [FIFO_DEPTH];
    logic signed [DATA_WIDTH-1:0] mem_im [FIFO_DEPTH];
    logic [PW-1:0]                rd_ptr, wr_ptr;
    logic [CW-1:0]                cnt;
    logic                         err_ovf, err_unf;

    logic empty, full, bypass, pop, push, ovf, unf, pair;
    logic signed [DATA_WIDTH-1:0] op_re, op_im;
    logic signed [DATA_WIDTH:0]   a_re_ext, a_im_ext, b_re_ext, b_im_ext;
    logic signed [DATA_WIDTH:0]   sum_re, sum_im, dif_re, dif_im;

    logic                         vld_p1;
    logic signed [DATA_WIDTH-1:0] x_re_p1, x_im_p1, y_re_p1, y_im_p1;

    // An A arriving together with B on an empty FIFO pairs directly and never lands in storage.
    assign empty  = (cnt == '0);
    assign full   = (cnt == CW'(FIFO_DEPTH));
    assign bypass = empty & bus.a_val & bus.b_val;
    assign pop    = bus.b_val & ~empty;
    assign push   = bus.a_val & ~bypass & (~full | pop);
    assign ovf    = bus.a_val & full & ~bus.b_val;
    assign unf    = bus.b_val & empty & ~bus.a_val;
    assign pair   = bypass | pop;

    assign op_re = bypass ? bus.a_re : mem_re[rd_ptr];
    assign op_im = bypass ? bus.a_im : mem_im[rd_ptr];

    assign a_re_ext = (DATA_WIDTH+1)'(op_re);
    assign a_im_ext = (DATA_WIDTH+1)'(op_im);
    assign b_re_ext = (DATA_WIDTH+1)'(bus.b_re);
    assign b_im_ext = (DATA_WIDTH+1)'(bus.b_im);
    assign sum_re   = a_re_ext + b_re_ext;
    assign sum_im   = a_im_ext + b_im_ext;
    assign dif_re   = a_re_ext - b_re_ext;
    assign dif_im   = a_im_ext - b_im_ext;

    always_ff @(posedge clk) begin
        if (push && !bus.clr) begin
            mem_re[wr_ptr] <= bus.a_re;
            mem_im[wr_ptr] <= bus.a_im;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            cnt     <= '0;
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
        end else if (bus.clr) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            cnt     <= '0;
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
            if (ovf) err_ovf <= 1'b1;
            if (unf) err_unf <= 1'b1;
        end
    end

    // ---- stage p1: registered butterfly outputs ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1  <= 1'b0;
            x_re_p1 <= '0;
            x_im_p1 <= '0;
            y_re_p1 <= '0;
            y_im_p1 <= '0;
        end else begin
            vld_p1 <= pair & ~bus.clr;
            if (pair && !bus.clr) begin
                x_re_p1 <= reduce(sum_re);
                x_im_p1 <= reduce(sum_im);
                y_re_p1 <= reduce(dif_re);
                y_im_p1 <= reduce(dif_im);
            end
        end
    end

    assign bus.out_val  = vld_p1;
    assign bus.x_re     = x_re_p1;
    assign bus.x_im     = x_im_p1;
    assign bus.y_re     = y_re_p1;
    assign bus.y_im     = y_im_p1;
    assign bus.fifo_cnt = cnt;
    assign bus.err_ovf  = err_ovf;
    assign bus.err_unf  = err_unf;
endmodule

// File: tb/tb_fft_bfly_align.sv
// Directed bench for fft_bfly_align; expected values follow FFT_BFLY_SCALE_EN when defined.
module tb_fft_bfly_align;
    localparam int DW = 16;
    localparam int FD = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    fft_bfly_align_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD)) bus();
    fft_bfly_align #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Butterfly reference for one component: sub=0 gives a+b, sub=1 gives a-b.
    function automatic logic [DW-1:0] bf(input int a, input int b, input bit sub);
        logic signed [DW:0] v;
        v = sub ? (DW+1)'(a) - (DW+1)'(b) : (DW+1)'(a) + (DW+1)'(b);
`ifdef FFT_BFLY_SCALE_EN
        return v[DW:1];
`else
        return v[DW-1:0];
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.clr = 1'b0; bus.a_val = 1'b0; bus.b_val = 1'b0;
    endtask

    task automatic drive_a(input int re, input int im);
        bus.a_val = 1'b1; bus.a_re = DW'(re); bus.a_im = DW'(im);
    endtask

    task automatic drive_b(input int re, input int im);
        bus.b_val = 1'b1; bus.b_re = DW'(re); bus.b_im = DW'(im);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle();
        bus.a_re = '0; bus.a_im = '0; bus.b_re = '0; bus.b_im = '0;
        #3;
        checks++; if (bus.out_val !== 1'b0) begin errors++; $display("FAIL reset_out_val got %0d want 0", bus.out_val); end
        checks++; if (bus.fifo_cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", bus.fifo_cnt); end
        checks++; if (bus.x_re !== 16'h0 || bus.y_im !== 16'h0) begin errors++; $display("FAIL reset_xy got x_re=%h y_im=%h want 0", bus.x_re, bus.y_im); end
        checks++; if ({bus.err_ovf, bus.err_unf} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {bus.err_ovf, bus.err_unf}); end
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_basic_pair();
        logic [DW-1:0] ex_re, ex_im, ey_re, ey_im;
`ifdef FFT_BFLY_SCALE_EN
        ex_re = 16'(65);  ex_im = 16'(-15); ey_re = 16'(35); ey_im = 16'(-35);
`else
        ex_re = 16'(130); ex_im = 16'(-30); ey_re = 16'(70); ey_im = 16'(-70);
`endif
        drive_a(100, -50);
        step();
        bus.a_val = 1'b0;
        checks++; if (bus.fifo_cnt !== 3'd1) begin errors++; $display("FAIL basic_cnt_push got %0d want 1", bus.fifo_cnt); end
        step();
        checks++; if (bus.out_val !== 1'b0) begin errors++; $display("FAIL basic_early_val got %0d want 0", bus.out_val); end
        drive_b(30, 20);
        step();
        bus.b_val = 1'b0;
        checks++; if (bus.out_val !== 1'b1) begin errors++; $display("FAIL basic_out_val got %0d want 1", bus.out_val); end
        checks++; if (bus.x_re !== ex_re || bus.x_im !== ex_im) begin errors++; $display("FAIL basic_x got (%h,%h) want (%h,%h)", bus.x_re, bus.x_im, ex_re, ex_im); end
        checks++; if (bus.y_re !== ey_re || bus.y_im !== ey_im) begin errors++; $display("FAIL basic_y got (%h,%h) want (%h,%h)", bus.y_re, bus.y_im, ey_re, ey_im); end
        checks++; if (bus.fifo_cnt !== 3'd0) begin errors++; $display("FAIL basic_cnt_pop got %0d want 0", bus.fifo_cnt); end
        step();
        checks++; if (bus.out_val !== 1'b0) begin errors++; $display("FAIL basic_pulse got %0d want 0", bus.out_val); end
        checks++; if (bus.x_re !== ex_re) begin errors++; $display("FAIL basic_hold got %h want %h", bus.x_re, ex_re); end
    endtask

    task automatic test_bypass_floor();
        logic [DW-1:0] e;
`ifdef FFT_BFLY_SCALE_EN
        e = 16'(-2);
`else
        e = 16'(-3);
`endif
        drive_a(-3, 0);
        drive_b(0, 0);
        step();
        idle();
        checks++; if (bus.out_val !== 1'b1) begin errors++; $display("FAIL bypass_val got %0d want 1", bus.out_val); end
        checks++; if (bus.x_re !== e || bus.y_re !== e) begin errors++; $display("FAIL bypass_floor got (%h,%h) want %h", bus.x_re, bus.y_re, e); end
        checks++; if (bus.fifo_cnt !== 3'd0) begin errors++; $display("FAIL bypass_cnt got %0d want 0", bus.fifo_cnt); end
        checks++; if (bus.err_unf !== 1'b0) begin errors++; $display("FAIL bypass_unf got %0d want 0", bus.err_unf); end
    endtask

    task automatic test_wrap();
        logic [DW-1:0] ex, ey;
`ifdef FFT_BFLY_SCALE_EN
        ex = 16'h4000; ey = 16'h3FFF;
`else
        ex = 16'h8000; ey = 16'h7FFE;
`endif
        drive_a(32'h7FFF, 0);
        drive_b(1, 0);
        step();
        idle();
        checks++; if (bus.x_re !== ex) begin errors++; $display("FAIL wrap_x got %h want %h", bus.x_re, ex); end
        checks++; if (bus.y_re !== ey) begin errors++; $display("FAIL wrap_y got %h want %h", bus.y_re, ey); end
    endtask

    task automatic test_underflow();
        logic [DW-1:0] held;
        held = bus.x_re;
        drive_b(9, 9);
        step();
        idle();
        checks++; if (bus.out_val !== 1'b0) begin errors++; $display("FAIL unf_val got %0d want 0", bus.out_val); end
        checks++; if (bus.err_unf !== 1'b1) begin errors++; $display("FAIL unf_flag got %0d want 1", bus.err_unf); end
        step();
        checks++; if (bus.err_unf !== 1'b1 || bus.x_re !== bf(32'h7FFF, 1, 0)) begin errors++; $display("FAIL unf_sticky got flag=%0d x_re=%h want 1 %h", bus.err_unf, bus.x_re, held); end
    endtask

    task automatic test_fifo_full();
        int order [4] = '{200, 300, 400, 600};
        bus.clr = 1'b1;
        step();
        bus.clr = 1'b0;
        checks++; if (bus.err_unf !== 1'b0) begin errors++; $display("FAIL clr_unf got %0d want 0", bus.err_unf); end
        for (int k = 1; k <= 4; k++) begin
            drive_a(k * 100, -k);
            step();
        end
        checks++; if (bus.fifo_cnt !== 3'd4 || bus.err_ovf !== 1'b0) begin errors++; $display("FAIL full_cnt got cnt=%0d ovf=%0d want 4 0", bus.fifo_cnt, bus.err_ovf); end
        drive_a(500, -5);
        step();
        checks++; if (bus.fifo_cnt !== 3'd4 || bus.err_ovf !== 1'b1) begin errors++; $display("FAIL ovf got cnt=%0d ovf=%0d want 4 1", bus.fifo_cnt, bus.err_ovf); end
        drive_a(600, -6);
        drive_b(2, 1);
        step();
        bus.a_val = 1'b0;
        checks++; if (bus.fifo_cnt !== 3'd4 || bus.err_ovf !== 1'b1) begin errors++; $display("FAIL full_pushpop got cnt=%0d ovf=%0d want 4 1", bus.fifo_cnt, bus.err_ovf); end
        checks++; if (bus.out_val !== 1'b1 || bus.x_re !== bf(100, 2, 0) || bus.y_im !== bf(-1, 1, 1)) begin errors++; $display("FAIL full_first got val=%0d x_re=%h y_im=%h want 1 %h %h", bus.out_val, bus.x_re, bus.y_im, bf(100, 2, 0), bf(-1, 1, 1)); end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (bus.out_val !== 1'b1 || bus.x_re !== bf(order[i], 2, 0) || bus.y_re !== bf(order[i], 2, 1)) begin errors++; $display("FAIL order_%0d got val=%0d x_re=%h y_re=%h want 1 %h %h", i, bus.out_val, bus.x_re, bus.y_re, bf(order[i], 2, 0), bf(order[i], 2, 1)); end
        end
        bus.b_val = 1'b0;
        checks++; if (bus.fifo_cnt !== 3'd0) begin errors++; $display("FAIL drain_cnt got %0d want 0", bus.fifo_cnt); end
    endtask

    task automatic test_clr_mid();
        for (int k = 1; k <= 3; k++) begin
            drive_a(k * 10, k);
            step();
        end
        bus.a_val = 1'b0;
        bus.clr = 1'b1;
        drive_b(1, 1);
        step();
        idle();
        checks++; if (bus.fifo_cnt !== 3'd0 || bus.out_val !== 1'b0) begin errors++; $display("FAIL clr_state got cnt=%0d val=%0d want 0 0", bus.fifo_cnt, bus.out_val); end
        checks++; if ({bus.err_ovf, bus.err_unf} !== 2'b00) begin errors++; $display("FAIL clr_flags got %b want 00", {bus.err_ovf, bus.err_unf}); end
        checks++; if (bus.x_re !== bf(600, 2, 0)) begin errors++; $display("FAIL clr_hold got %h want %h", bus.x_re, bf(600, 2, 0)); end
        drive_a(7, 7);
        drive_b(1, 1);
        step();
        idle();
        checks++; if (bus.out_val !== 1'b1 || bus.x_re !== bf(7, 1, 0) || bus.y_im !== bf(7, 1, 1)) begin errors++; $display("FAIL clr_after got val=%0d x_re=%h y_im=%h want 1 %h %h", bus.out_val, bus.x_re, bus.y_im, bf(7, 1, 0), bf(7, 1, 1)); end
    endtask

    task automatic test_reset_mid();
        for (int k = 2; k <= 4; k++) begin
            drive_a(k * 10, 0);
            step();
        end
        idle();
        #2 rst = 1'b0;
        #1;
        checks++; if (bus.out_val !== 1'b0 || bus.x_re !== 16'h0 || bus.y_im !== 16'h0) begin errors++; $display("FAIL rstmid_out got val=%0d x_re=%h y_im=%h want 0", bus.out_val, bus.x_re, bus.y_im); end
        checks++; if (bus.fifo_cnt !== 3'd0) begin errors++; $display("FAIL rstmid_cnt got %0d want 0", bus.fifo_cnt); end
        #2 rst = 1'b1;
        step();
        drive_a(55, 5);
        step();
        bus.a_val = 1'b0;
        drive_b(5, 5);
        step();
        idle();
        checks++; if (bus.out_val !== 1'b1 || bus.x_re !== bf(55, 5, 0) || bus.y_re !== bf(55, 5, 1)) begin errors++; $display("FAIL rstmid_pair got val=%0d x_re=%h y_re=%h want 1 %h %h", bus.out_val, bus.x_re, bus.y_re, bf(55, 5, 0), bf(55, 5, 1)); end
        checks++; if (bus.fifo_cnt !== 3'd0) begin errors++; $display("FAIL rstmid_empty got %0d want 0", bus.fifo_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic_pair();
        test_bypass_floor();
        test_wrap();
        test_underflow();
        test_fifo_full();
        test_clr_mid();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fft_bfly_align.md
Name: fft_bfly_align

Overview:
- Radix-2 DIT butterfly stage directly downstream of the twiddle factor multiplier.
- Buffers the un-rotated upper-leg sample A in a small FIFO until the matching twiddle-rotated lower-leg sample W·B arrives from the multiplier (2-cycle latency, enable-gated).
- Produces X = A + W·B and Y = A − W·B with a registered valid strobe.
- Owns alignment, error flagging and optional 1-bit stage scaling.

Parameters:
- DATA_WIDTH, 16, width of each real/imag component; signed two's complement.
- FIFO_DEPTH, 4, number of A entries buffered; must be a power of two, ≥2.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- clr  in  1  synchronous flush: empties FIFO, clears error flags, drops in-flight output
- a_val  in  1  A sample valid (push)
- a_re  in  DATA_WIDTH  A real
- a_im  in  DATA_WIDTH  A imaginary
- b_val  in  1  rotated B valid; driven from multiplier out_val
- b_re  in  DATA_WIDTH  rotated B real
- b_im  in  DATA_WIDTH  rotated B imaginary
- x_re  out  DATA_WIDTH  X = A+B real
- x_im  out  DATA_WIDTH  X imaginary
- y_re  out  DATA_WIDTH  Y = A−B real
- y_im  out  DATA_WIDTH  Y imaginary
- out_val  out  1  X/Y valid, one-cycle pulse per pair
- fifo_cnt  out  $clog2(FIFO_DEPTH)+1  current A occupancy
- err_ovf  out  1  sticky: A push dropped because FIFO was full
- err_unf  out  1  sticky: B arrived with no A available

Behaviour:
- Reset (rst low, async): all outputs 0, FIFO empty, rd/wr pointers 0, flags 0.
- Push: on a_val, A is written to the FIFO tail.
- Pop: on b_val with an A available, the head A is consumed.
- Pairing is strictly in order: the k-th consumed B pairs with the k-th accepted A.
- Bypass: FIFO empty and a_val & b_val in the same cycle:
  - incoming A pairs directly with B;
  - nothing is written; fifo_cnt stays 0;
  - no underflow.
- Full with a_val & b_val in the same cycle: pop and push both happen, count unchanged, no overflow.
- Full with a_val and no b_val: A dropped, count unchanged, err_ovf set to 1 on the next edge.
- b_val with FIFO empty and no a_val: B discarded, no output, err_unf set to 1.
- Error flags are sticky until clr or reset.
- Arithmetic:
  - operands sign-extended to DATA_WIDTH+1; sum/difference computed per component at that width;
  - reduced to DATA_WIDTH per the Optional Feature;
  - results registered.
- Latency: out_val and X/Y valid on the clock edge after the b_val cycle that formed a pair (1 cycle). out_val is 0 in every other cycle.
- X/Y hold their last value when out_val is 0.
- Throughput: one pair per cycle, sustained.
- Pointers wrap modulo FIFO_DEPTH; the occupancy counter distinguishes full from empty.
- clr:
  - takes priority over push, pop and flag setting in the same cycle;
  - next cycle: fifo_cnt=0, err flags=0, out_val=0;
  - X/Y data regs unchanged.
- Reset mid-stream: immediate async clear; buffered A samples are lost; the first push after rst release lands at entry 0.

Optional Feature:
- Macro: FFT_BFLY_SCALE_EN
- Defined: each result is arithmetic-shifted right by 1 from the DATA_WIDTH+1 value, taking bits [DATA_WIDTH:1]. This halves stage gain and guarantees no overflow.
- Undefined: bits [DATA_WIDTH-1:0] of the DATA_WIDTH+1 value are taken. Overflow wraps silently; no saturation.

Test Plan:
- Basic pair, DATA_WIDTH=16, scale off: push A=(100,−50), then 2 cycles later b_val with B=(30,20). Expect out_val one cycle later, X=(130,−30), Y=(70,−70), fifo_cnt 1→0.
- Same stimulus with FFT_BFLY_SCALE_EN defined: expect X=(65,−15), Y=(35,−35). Second check: A=(−3,0), B=(0,0) → X_re=Y_re=−2 (floor).
- Wrap/overflow arithmetic:
  - scale off: A_re=0x7FFF, B_re=0x0001 → X_re=0x8000, Y_re=0x7FFE;
  - scale on: X_re=0x4000, Y_re=0x3FFF.
- FIFO boundaries, FIFO_DEPTH=4:
  - push 4 A with no B → fifo_cnt=4;
  - 5th push → err_ovf=1, count stays 4;
  - then simultaneous a_val&b_val → count stays 4, err_ovf stays 1;
  - 4 further B → outputs pair in push order (5th dropped A never appears).
- Bypass and underflow:
  - empty FIFO, a_val&b_val same cycle → out_val next cycle, fifo_cnt stays 0, err_unf=0;
  - lone b_val on empty FIFO → no out_val, err_unf=1.
- clr/reset mid-stream:
  - 3 A buffered, clr asserted in the same cycle as b_val → next cycle fifo_cnt=0, out_val=0, flags 0;
  - repeat with rst pulsed low mid-cycle → outputs 0 immediately, FIFO empty after release.
